// File: rtl/fifo_mac_pkg.sv
// fifo_mac_pkg
//   Shared definitions for the two-stream multiply-accumulate engine.
//   - mac_out_width(): accumulator/result width that cannot overflow for
//     PACKET_LEN products of two WIDTH-bit operands.
//   - prod_stage_t: the product pipeline register.
//     The product is held sign- or zero-extended to MAX_PROD_W bits so one
//     struct type serves every parameterisation with WIDTH < 32.
package fifo_mac_pkg;

  localparam int MAX_PROD_W = 64;

  typedef struct packed {
    logic [MAX_PROD_W-1:0] prod;
    logic                  prod_v;
  } prod_stage_t;

  function automatic int mac_out_width(input int width, input int packet_len);
    return 2 * width + $clog2(packet_len);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with a flop-based array. The head word is read
//   straight from the storage flops, so rd_data is valid whenever !empty.
//   No same-cycle pass-through: a write while full is dropped even if a
//   read happens in the same cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_en, wr_data      push request and data (ignored when full or in reset)
//   rd_en               pop request (ignored when empty)
//   rd_data             current head word
//   full, empty, count  occupancy status
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_wr, do_rd;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign do_wr   = wr_en && !full && !rst;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fifo_mac_stream_acc.sv
// fifo_mac_stream_acc
//   Buffers two operand streams in separate FIFOs, pops one word from each
//   together, multiplies them (stage 1) and sums PACKET_LEN consecutive
//   products into one result (stage 2) presented on a registered output.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   data_in1/valid_in1/ready_1       stream 1 input
//   data_in2/valid_in2/ready_2       stream 2 input
//   data_o/valid_o/ready_o           result output
// Handshake (all three interfaces): a word transfers on a rising edge where
//   valid && ready are both high. valid_o/data_o stay stable until taken.
//   ready_k depends only on FIFO fullness and rst, never on valid_ink.
module fifo_mac_stream_acc
  import fifo_mac_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int PACKET_LEN = 4,
  parameter int SIGNED     = 0,
  localparam int OUT_W     = mac_out_width(WIDTH, PACKET_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in1,
  input  logic             valid_in1,
  output logic             ready_1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic             valid_in2,
  output logic             ready_2,
  output logic [OUT_W-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_o
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int AW     = $clog2(DEPTH);
  localparam int CNT_W  = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

  logic [WIDTH-1:0] head1, head2;
  logic             full1, full2, empty1, empty2;
  logic [AW:0]      count1, count2;
  logic             en, pop;

  // Fill levels are available on the FIFO instances for observation only.
  logic unused_count;
  assign unused_count = ^{count1, count2};

  assign ready_1 = !full1 && !rst;
  assign ready_2 = !full2 && !rst;
  // The whole pipeline moves only when the output register can take a result.
  assign en      = !valid_o_q || ready_o;
  assign pop     = en && !empty1 && !empty2;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .wr_en(valid_in1 && ready_1), .wr_data(data_in1),
    .rd_en(pop), .rd_data(head1), .full(full1), .empty(empty1), .count(count1)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
    .clk(clk), .rst(rst), .wr_en(valid_in2 && ready_2), .wr_data(data_in2),
    .rd_en(pop), .rd_data(head2), .full(full2), .empty(empty2), .count(count2)
  );

  prod_stage_t      prod_q, prod_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] data_o_q, data_o_d;
  logic             valid_o_q, valid_o_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  logic [PROD_W-1:0] a_ext, b_ext, prod_raw;
  logic [OUT_W-1:0]  sum;
  logic              last;

  assign data_o  = data_o_q;
  assign valid_o = valid_o_q;

  always_comb begin
    // The low PROD_W bits of a product of extended operands are correct for
    // both unsigned and two's-complement interpretation.
    if (SIGNED != 0) begin
      a_ext = {{WIDTH{head1[WIDTH-1]}}, head1};
      b_ext = {{WIDTH{head2[WIDTH-1]}}, head2};
    end else begin
      a_ext = {{WIDTH{1'b0}}, head1};
      b_ext = {{WIDTH{1'b0}}, head2};
    end
    prod_raw = a_ext * b_ext;

    prod_d = prod_q;
    if (en) begin
      if (SIGNED != 0) prod_d.prod = {{(MAX_PROD_W-PROD_W){prod_raw[PROD_W-1]}}, prod_raw};
      else             prod_d.prod = {{(MAX_PROD_W-PROD_W){1'b0}}, prod_raw};
      prod_d.prod_v = pop;
    end

    // Truncation is exact: the product was extended with its own sign rule.
    sum  = acc_q + OUT_W'(prod_q.prod);
    last = (pkt_cnt_q == CNT_W'(PACKET_LEN - 1));

    acc_d     = acc_q;
    pkt_cnt_d = pkt_cnt_q;
    data_o_d  = data_o_q;
    valid_o_d = valid_o_q;
    if (valid_o_q && ready_o) valid_o_d = 1'b0;
    if (en && prod_q.prod_v) begin
      if (last) begin
        data_o_d  = sum;
        valid_o_d = 1'b1;
        acc_d     = '0;
        pkt_cnt_d = '0;
      end else begin
        acc_d     = sum;
        pkt_cnt_d = pkt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q    <= '0;
      acc_q     <= '0;
      pkt_cnt_q <= '0;
      data_o_q  <= '0;
      valid_o_q <= 1'b0;
    end else begin
      prod_q    <= prod_d;
      acc_q     <= acc_d;
      pkt_cnt_q <= pkt_cnt_d;
      data_o_q  <= data_o_d;
      valid_o_q <= valid_o_d;
    end
  end

endmodule

// File: doc/fifo_mac_stream_acc.md
Name: fifo_mac_stream_acc

Overview:
Two-stream multiply-accumulate engine with per-stream input buffering. Each input stream is buffered in its own synchronous FIFO. Pairs of words, one from each FIFO, are multiplied, and PACKET_LEN consecutive products are summed into one result. Results leave on a valid/ready output with full backpressure. The block sits between two independent producers and a downstream consumer and adds signed mode, output backpressure and a derived, overflow-free output width.

Parameters:
WIDTH, 8, operand width of each input stream.
DEPTH, 16, per-stream FIFO depth in words; power of two, >= 2.
PACKET_LEN, 4, number of products summed per output result; >= 1.
SIGNED, 0, 0 = unsigned operands and result, 1 = two's-complement operands and result.
OUT_W (localparam), 2*WIDTH + $clog2(PACKET_LEN), output width.

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
data_in1  input  WIDTH  stream 1 operand
valid_in1  input  1  stream 1 word valid
ready_1  output  1  stream 1 may write
data_in2  input  WIDTH  stream 2 operand
valid_in2  input  1  stream 2 word valid
ready_2  output  1  stream 2 may write
data_o  output  OUT_W  accumulated packet result
valid_o  output  1  data_o valid
ready_o  input  1  downstream accepts data_o

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset: FIFO pointers and counts, product stage, accumulator, packet counter, data_o and valid_o all clear to 0. While rst is high, ready_1 and ready_2 are 0 and writes are ignored.
- ready_k = !full_k && !rst. A write happens when valid_ink && ready_k.
- Full FIFO: no same-cycle pass-through. A write at full is refused even if a pop occurs in the same cycle.
- Empty FIFO: a word written in cycle w is poppable no earlier than w+1.
- Global advance enable: en = !valid_o || ready_o.
- Pop: when en && !empty1 && !empty2, pop the head of both FIFOs together. Streams are never popped singly.
- Stage 1 (pop cycle t): prod <= a*b, registered at t+1, with prod_v set. Operands are zero-extended when SIGNED=0 and sign-extended when SIGNED=1. prod is 2*WIDTH bits.
- Stage 2 (t+2, when prod_v && en):
  - Not last product: acc <= acc + prod, pkt_cnt++.
  - Last product (pkt_cnt == PACKET_LEN-1): data_o <= acc + prod, valid_o <= 1, acc <= 0, pkt_cnt <= 0.
- Latency: valid_o rises 2 cycles after the pop of the last pair in a packet. From write of the last pair to valid_o is at least 3 cycles.
- Stall (en=0): prod, prod_v, acc and pkt_cnt hold, and no pop occurs. data_o and valid_o hold stable until ready_o.
- Accept cycle: valid_o && ready_o clears valid_o unless a new result completes in the same cycle. Back-to-back results are allowed, giving one result per cycle when PACKET_LEN=1.
- Width: OUT_W guarantees no overflow.
  - Unsigned: PACKET_LEN*(2^WIDTH-1)^2 < 2^OUT_W.
  - Signed: the magnitude bound is the same.
  - No saturation or wrap logic.
- Rate mismatch: the faster stream's FIFO fills and its ready drops; the slower stream is unaffected. Nothing is lost.
- Reset mid-operation discards buffered words and the partial sum. The next result contains only post-reset pairs.

Decomposition:
- Package fifo_mac_pkg:
  - function mac_out_width(WIDTH, PACKET_LEN).
  - typedef for stage-1 product-valid struct {prod, prod_v}.
- Sub-module sync_fifo #(WIDTH, DEPTH), instantiated twice.
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data (registered head, valid when !empty), full, empty, count.
  - Wrap-around uses pointers of $clog2(DEPTH)+1 bits.
- Top level holds the pop control, the product stage, the accumulator, pkt_cnt and the output register.

Test Plan:
1. Defaults, unsigned, ready_o=1: in1 = 1,2,3,4 and in2 = 5,6,7,8 -> single valid_o pulse with data_o = 70, 3 cycles after the last write.
2. Unsigned maximum: 255*255 four times -> data_o = 260100 (18-bit OUT_W, no overflow). Then pairs 1*1 four times -> data_o = 4, confirming the accumulator cleared.
3. SIGNED=1:
   - (-128)*(-128) x4 -> data_o = 65536.
   - (-128)*127 x4 -> data_o = -65024 (18-bit two's complement 0x30200).
4. Backpressure: ready_o=0 for 40 cycles while both streams push continuously ->
   - data_o held constant.
   - ready_1 and ready_2 fall after DEPTH words plus words absorbed by the pipeline.
   - After ready_o=1, every result arrives in order; total results = pairs/4, none lost or duplicated.
5. Rate mismatch: only valid_in1 for 20 cycles -> ready_1 low after 16 writes and no valid_o. Then 16 stream-2 words -> exactly 4 results.
6. Reset mid-packet: 2 pairs (3*3, 3*3) popped, then rst for 1 cycle, then 4 pairs of 1*2 -> data_o = 8, with ready_k=0 during the reset cycle.
